// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds,
// pause back-pressure and a sticky overflow/underflow error flag.
// UMBRAL_WIDTH must equal ADDR_WIDTH.
module fifo_flow_ctrl #(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH   = 2,
  parameter int unsigned UMBRAL_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_almost_empty,
  input  logic [UMBRAL_WIDTH-1:0] umbral_almost_full,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    pause,
  output logic                    fifo_error,
  output logic [ADDR_WIDTH:0]     occupancy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned OCC_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [UMBRAL_WIDTH-1:0] ae_thr;
  logic [UMBRAL_WIDTH-1:0] af_thr;

  logic                    pop_acc;
  logic                    push_acc;
  logic                    overflow;
  logic                    underflow;
  logic [OCC_W-1:0]        occ_nxt;
  logic [UMBRAL_WIDTH-1:0] ae_nxt;
  logic [UMBRAL_WIDTH-1:0] af_nxt;

  // Acceptance and error qualification; a pop frees the slot a full-FIFO push needs
  always_comb begin
    pop_acc   = pop & ~fifo_empty;
    push_acc  = push & (~fifo_full | pop_acc);
    overflow  = push & fifo_full & ~pop_acc;
    underflow = pop & fifo_empty;
  end

  // Next occupancy and thresholds, so the flags can be registered yet track them
  always_comb begin
    occ_nxt = occupancy;
    ae_nxt  = ae_thr;
    af_nxt  = af_thr;
    if (init) begin
      occ_nxt = '0;
      ae_nxt  = umbral_almost_empty;
      af_nxt  = umbral_almost_full;
    end else if (push_acc && !pop_acc) begin
      occ_nxt = occupancy + OCC_W'(1);
    end else if (pop_acc && !push_acc) begin
      occ_nxt = occupancy - OCC_W'(1);
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (reset && !init && push_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read port and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
      ae_thr     <= UMBRAL_WIDTH'(1);
      af_thr     <= UMBRAL_WIDTH'(DEPTH - 1);
    end else if (init) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
      ae_thr     <= umbral_almost_empty;
      af_thr     <= umbral_almost_full;
    end else begin
      occupancy <= occ_nxt;
      valid_out <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (overflow || underflow) begin
        fifo_error <= 1'b1;
      end
    end
  end

  // Status flags registered from next occupancy/thresholds (same timing as decoding the counter)
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      pause        <= 1'b0;
    end else begin
      fifo_full    <= (occ_nxt == OCC_W'(DEPTH));
      fifo_empty   <= (occ_nxt == '0);
      almost_full  <= (occ_nxt >= OCC_W'(af_nxt));
      almost_empty <= (occ_nxt <= OCC_W'(ae_nxt));
      pause        <= (occ_nxt >= OCC_W'(af_nxt));
    end
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Self-checking bench for fifo_flow_ctrl: queue-based reference model compared
// every cycle, plus directed literal checks from the test plan.
module tb_fifo_flow_ctrl;

  localparam int unsigned DW    = 6;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [AW-1:0] umbral_almost_empty;
  logic [AW-1:0] umbral_almost_full;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic          pause;
  logic          fifo_error;
  logic [AW:0]   occupancy;

  int tests = 0;
  int fails = 0;

  fifo_flow_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UMBRAL_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_almost_empty(umbral_almost_empty),
    .umbral_almost_full(umbral_almost_full),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .pause(pause), .fifo_error(fifo_error), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of words plus thresholds, error, and read register
  logic [DW-1:0] q[$];
  int            m_ae, m_af;
  logic          m_err, m_vout;
  logic [DW-1:0] m_dout;
  logic          m_live = 1'b0;

  always @(posedge clk) begin
    int  sz;
    bit  pop_ok, push_ok;
    sz = q.size();
    if (!reset) begin
      q.delete();
      m_ae = 1; m_af = DEPTH - 1;
      m_err = 1'b0; m_vout = 1'b0; m_dout = '0;
      m_live = 1'b1;
    end else if (init) begin
      q.delete();
      m_ae = int'(umbral_almost_empty);
      m_af = int'(umbral_almost_full);
      m_err = 1'b0; m_vout = 1'b0;
    end else begin
      pop_ok  = pop && (sz != 0);
      push_ok = push && ((sz != DEPTH) || pop_ok);
      if ((push && !push_ok) || (pop && sz == 0)) m_err = 1'b1;
      m_vout = pop_ok;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(data_in);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    int sz;
    if (m_live) begin
      sz = q.size();
      chk("occupancy",    int'(occupancy),    sz);
      chk("fifo_full",    int'(fifo_full),    int'(sz == DEPTH));
      chk("fifo_empty",   int'(fifo_empty),   int'(sz == 0));
      chk("almost_full",  int'(almost_full),  int'(sz >= m_af));
      chk("almost_empty", int'(almost_empty), int'(sz <= m_ae));
      chk("pause",        int'(pause),        int'(sz >= m_af));
      chk("fifo_error",   int'(fifo_error),   int'(m_err));
      chk("valid_out",    int'(valid_out),    int'(m_vout));
      if (m_vout) chk("data_out", int'(data_out), int'(m_dout));
    end
  end

  // One clock: drive inputs after the falling edge, return just after the rising edge
  task automatic tick(input logic r, input logic i, input logic ps,
                      input logic [DW-1:0] d, input logic pp);
    @(negedge clk);
    reset = r; init = i; push = ps; data_in = d; pop = pp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input int ae, input int af);
    umbral_almost_empty = AW'(ae);
    umbral_almost_full  = AW'(af);
    tick(1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] exp_rd [4];
    reset = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_almost_empty = '0; umbral_almost_full = '0;

    // 1: reset two cycles
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_err", int'(fifo_error), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_pause", int'(pause), 0);

    // 2: thresholds AE=1 AF=3, three pushes
    do_init(1, 3);
    tick(1'b1, 1'b0, 1'b1, 6'h11, 1'b0);
    chk("p1_occ", int'(occupancy), 1);
    chk("p1_ae", int'(almost_empty), 1);
    tick(1'b1, 1'b0, 1'b1, 6'h22, 1'b0);
    chk("p2_ae", int'(almost_empty), 0);
    chk("p2_af", int'(almost_full), 0);
    tick(1'b1, 1'b0, 1'b1, 6'h33, 1'b0);
    chk("p3_occ", int'(occupancy), 3);
    chk("p3_pause", int'(pause), 1);

    // 3: fill to 4 then drain
    tick(1'b1, 1'b0, 1'b1, 6'h2A, 1'b0);
    chk("fill_full", int'(fifo_full), 1);
    exp_rd[0] = 6'h11; exp_rd[1] = 6'h22; exp_rd[2] = 6'h33; exp_rd[3] = 6'h2A;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
      chk("drain_valid", int'(valid_out), 1);
      chk("drain_data", int'(data_out), int'(exp_rd[k]));
    end
    chk("drain_empty", int'(fifo_empty), 1);
    chk("drain_err", int'(fifo_error), 0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("idle_valid", int'(valid_out), 0);

    // 4: overflow drops the write
    for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0, 1'b1, DW'(k), 1'b0);
    tick(1'b1, 1'b0, 1'b1, 6'h3F, 1'b0);
    chk("ovf_err", int'(fifo_error), 1);
    chk("ovf_occ", int'(occupancy), 4);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("ovf_first", int'(data_out), 1);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("ovf_last", int'(data_out), 4);

    // 5: full FIFO with simultaneous push and pop
    do_init(1, 3);
    for (int k = 5; k <= 8; k++) tick(1'b1, 1'b0, 1'b1, DW'(k), 1'b0);
    tick(1'b1, 1'b0, 1'b1, 6'h09, 1'b1);
    chk("pp_occ", int'(occupancy), 4);
    chk("pp_err", int'(fifo_error), 0);
    chk("pp_data", int'(data_out), 5);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("pp_last", int'(data_out), 9);

    // 6: underflow, init clears, reset mid-burst
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("udf_err", int'(fifo_error), 1);
    chk("udf_valid", int'(valid_out), 0);
    do_init(1, 3);
    chk("init_err", int'(fifo_error), 0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1, DW'(20 + k), 1'b0);
    tick(1'b0, 1'b0, 1'b1, 6'h15, 1'b1);
    chk("mid_rst_occ", int'(occupancy), 0);
    chk("mid_rst_empty", int'(fifo_empty), 1);
    chk("mid_rst_valid", int'(valid_out), 0);

    // Push+pop on empty: push accepted, pop is an underflow
    tick(1'b1, 1'b0, 1'b1, 6'h2C, 1'b1);
    chk("nft_occ", int'(occupancy), 1);
    chk("nft_err", int'(fifo_error), 1);
    chk("nft_valid", int'(valid_out), 0);

    // Threshold corners: AE=0, AF=0
    do_init(0, 0);
    chk("af0_pause", int'(pause), 1);
    chk("ae0_empty", int'(almost_empty), 1);
    tick(1'b1, 1'b0, 1'b1, 6'h07, 1'b0);
    chk("ae0_one", int'(almost_empty), 0);
    chk("af0_err", int'(fifo_error), 0);

    // Pseudo-random traffic against the model with varying thresholds
    for (int n = 0; n < 300; n++) begin
      if (n % 60 == 0) do_init(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
